// File: rtl/add_round_key_stage_if.sv
// Streaming handshake bundle for the AddRoundKey stage: input word channel and output word channel.
interface add_round_key_stage_if;
    logic         Ark_in_valid;
    logic         Ark_in_ready;
    logic [127:0] Ark_in;
    logic [3:0]   Ark_in_round;
    logic         Ark_out_valid;
    logic         Ark_out_ready;
    logic [127:0] Ark_out;
    logic [3:0]   Ark_out_round;
    logic         Ark_out_imc_en;

    modport slave (
        input  Ark_in_valid, Ark_in, Ark_in_round, Ark_out_ready,
        output Ark_in_ready, Ark_out_valid, Ark_out, Ark_out_round, Ark_out_imc_en
    );

    modport master (
        output Ark_in_valid, Ark_in, Ark_in_round, Ark_out_ready,
        input  Ark_in_ready, Ark_out_valid, Ark_out, Ark_out_round, Ark_out_imc_en
    );
endinterface

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage: XORs each state word with its round key from a local key store,
// one-deep registered output with valid/ready flow control and a sticky error flag.
module add_round_key_stage #(
    parameter int unsigned NUM_KEYS = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Key_wr_en,
    input  logic [3:0]                Key_wr_addr,
    input  logic [127:0]              Key_wr_data,
    input  logic                      Key_clear,
    input  logic                      Ark_err_clr,
    output logic                      Ark_err,
    add_round_key_stage_if.slave      ark
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [DATA_W-1:0]   key_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_vld_q;
    logic [NUM_KEYS-1:0] key_vld_d;

    logic             wr_in_range;
    logic             wr_ok;
    logic             wr_bad;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_ok;
    logic             xfer;
    logic             drop;
    logic             imc_d;
    logic             err_d;

    assign wr_in_range = 32'(Key_wr_addr) < NUM_KEYS;
    assign wr_ok       = Key_wr_en && wr_in_range;
    assign wr_bad      = Key_wr_en && !wr_in_range;
    assign wr_idx      = wr_in_range ? IDX_W'(Key_wr_addr) : '0;

    assign rd_in_range = 32'(ark.Ark_in_round) < NUM_KEYS;
    assign rd_idx      = rd_in_range ? IDX_W'(ark.Ark_in_round) : '0;
    assign rd_ok       = rd_in_range && key_vld_q[rd_idx];

    // Output register is free when empty or being drained this cycle.
    assign ark.Ark_in_ready = !ark.Ark_out_valid || ark.Ark_out_ready;
    assign xfer             = ark.Ark_in_valid && ark.Ark_in_ready;
    assign drop             = xfer && !rd_ok;

    // InvMixColumns is skipped for the first and last key additions.
    assign imc_d = (ark.Ark_in_round != '0) && (32'(ark.Ark_in_round) + 32'd2 <= NUM_KEYS);

    // Clear invalidates every slot, but a concurrent write re-validates its own slot.
    always_comb begin
        key_vld_d = key_vld_q;
        if (Key_clear) begin
            key_vld_d = '0;
        end
        if (wr_ok) begin
            key_vld_d[wr_idx] = 1'b1;
        end
    end

    // A fresh error in the same cycle overrides the clear pulse.
    always_comb begin
        err_d = Ark_err;
        if (wr_bad || drop) begin
            err_d = 1'b1;
        end else if (Ark_err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                key_q[i] <= '0;
            end
            key_vld_q <= '0;
        end else begin
            if (wr_ok) begin
                key_q[wr_idx] <= Key_wr_data;
            end
            key_vld_q <= key_vld_d;
        end
    end

    // Reads use the pre-edge key, so a same-cycle write to that slot cannot leak into the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ark.Ark_out_valid  <= 1'b0;
            ark.Ark_out        <= '0;
            ark.Ark_out_round  <= '0;
            ark.Ark_out_imc_en <= 1'b0;
            Ark_err            <= 1'b0;
        end else begin
            Ark_err <= err_d;
            if (xfer && rd_ok) begin
                ark.Ark_out_valid  <= 1'b1;
                ark.Ark_out        <= ark.Ark_in ^ key_q[rd_idx];
                ark.Ark_out_round  <= ark.Ark_in_round;
                ark.Ark_out_imc_en <= imc_d;
            end else if (ark.Ark_out_ready) begin
                ark.Ark_out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 Parameter NUM_KEYS, default 11, SHALL be the number of round-key slots (AES-128: rounds 0..10).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Key_wr_en  input  1  SHALL be the round-key write strobe.
REQ-005 Key_wr_addr  input  4  SHALL be the round-key slot index.
REQ-006 Key_wr_data  input  128  SHALL be the round key, byte 0 in bits [127:120].
REQ-007 Key_clear  input  1  SHALL be a pulse that invalidates all key slots.
REQ-008 Ark_in_valid / Ark_in_ready  input / output  1 / 1  SHALL be the input handshake.
REQ-009 Ark_in  input  128  SHALL be the state word; Ark_in_round  input  4  SHALL be its round index.
REQ-010 Ark_out_valid / Ark_out_ready  output / input  1 / 1  SHALL be the output handshake.
REQ-011 Ark_out  output  128  SHALL be the state XOR round key; Ark_out_round  output  4  SHALL echo the round index.
REQ-012 Ark_out_imc_en  output  1  SHALL indicate the downstream InvMixColumns stage applies to this word.
REQ-013 Ark_err  input Ark_err_clr 1 / output Ark_err 1  SHALL be a sticky error flag and its clear pulse.

Function
REQ-014 Key store SHALL hold NUM_KEYS x 128-bit registers plus a NUM_KEYS-bit valid bitmap.
REQ-015 Key_wr_en with Key_wr_addr < NUM_KEYS SHALL write the slot and set its valid bit the next edge.
REQ-016 Key_wr_en with Key_wr_addr >= NUM_KEYS SHALL leave the store unchanged and set Ark_err.
REQ-017 Key_clear SHALL clear all valid bits; key contents are retained; a same-cycle write SHALL set its own valid bit (write wins).
REQ-018 Ark_in_ready SHALL equal (!Ark_out_valid || Ark_out_ready), combinationally.
REQ-019 Transfer occurs when Ark_in_valid && Ark_in_ready; throughput one word per cycle; latency exactly 1 cycle.
REQ-020 On transfer with round < NUM_KEYS and slot valid: next edge Ark_out = Ark_in ^ key[round], Ark_out_round = round, Ark_out_valid = 1.
REQ-021 Key used SHALL be the pre-edge slot contents; a same-cycle write to that slot SHALL NOT affect the word.
REQ-022 On transfer with round >= NUM_KEYS or slot invalid: word SHALL be consumed and dropped, Ark_err set, Ark_out_valid cleared unless a valid word is concurrently held.
REQ-023 Ark_out_imc_en SHALL be 1 iff 1 <= Ark_out_round <= NUM_KEYS-2 (rounds 1..9), else 0.
REQ-024 With Ark_out_valid && !Ark_out_ready, all Ark_out* SHALL hold stable and no new word is accepted.
REQ-025 Output register SHALL clear Ark_out_valid when Ark_out_ready and no new transfer.
REQ-026 Ark_err SHALL stay set until Ark_err_clr; a same-cycle new error SHALL win over clear.

Reset
REQ-027 rst_n low SHALL immediately clear Ark_out_valid, Ark_out, Ark_out_round, Ark_out_imc_en, Ark_err, all key registers and valid bits.
REQ-028 Ark_in_ready SHALL be 1 during and after reset (output empty).
REQ-029 Reset mid-transfer SHALL discard the held word; no output after release until a new transfer.

Verification
REQ-030 Load slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; send 3925841d02dc09fbdc118597196a0b32, round 10 -> next cycle Ark_out = e9317db5cb322c723d2e895faf090794, round 10, imc_en 0.
REQ-031 Load slot 5 = all-ones; stream 4 back-to-back words round 5, Ark_out_ready held 1 -> 4 consecutive outputs, each bitwise-inverted input, imc_en 1, no bubbles.
REQ-032 Hold Ark_out_ready 0 for 3 cycles with output valid -> Ark_in_ready 0, Ark_out stable; release -> next word accepted same cycle.
REQ-033 Send round 12, then round 3 with slot 3 unloaded -> both dropped, no Ark_out_valid, Ark_err 1; Ark_err_clr -> Ark_err 0.
REQ-034 Same cycle: write slot 0 = 0 (previously 0x55..55) and transfer round 0 of 0x00..00 -> Ark_out = 0x55..55, imc_en 0; Key_clear then round 0 -> dropped, Ark_err 1.
REQ-035 Assert rst_n low while output held -> Ark_out_valid 0 asynchronously, all key slots invalid after release.
